// File: rtl/dvi_pkg.sv
// Shared types and line-code constants for the DVI link start-up controller.
package dvi_pkg;

    // Link controller states; encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_SYNC   = 2'b10,
        ST_ACTIVE = 2'b11
    } link_state_e;

    // CTRL-00 token 10'b1101010100, split into the two 5-bit serdes halves.
    localparam logic [4:0] CTRL_TOKEN_LO = 5'b10100;
    localparam logic [4:0] CTRL_TOKEN_HI = 5'b11010;

    // Clock lane: high during the low-half slot, low during the high-half slot.
    localparam logic [4:0] CLK_PAT_HI = 5'b11111;
    localparam logic [4:0] CLK_PAT_LO = 5'b00000;

    // 8-bit increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dvi_frame_sync.sv
// Vsync rising-edge detector and frame counter; raises pending once enough
// frame starts have been seen while counting is enabled.
module dvi_frame_sync
    import dvi_pkg::*;
#(
    parameter int SYNC_FRAMES = 2
) (
    input  logic clkx2in,
    input  logic serdes_reset,
    input  logic vsync_i,
    input  logic count_en_i,
    output logic pending_o
);

    localparam int FW = $clog2(SYNC_FRAMES + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(SYNC_FRAMES - 1);

    logic          vs_q;
    logic [FW-1:0] frames_q, frames_d;
    logic          pending_q, pending_d;
    logic          rise;

    assign rise      = vsync_i & ~vs_q;
    assign pending_o = pending_q;

    // Count rises only while enabled; leaving the counting window clears everything.
    always_comb begin
        frames_d  = frames_q;
        pending_d = pending_q;
        if (!count_en_i) begin
            frames_d  = '0;
            pending_d = 1'b0;
        end else if (rise && !pending_q) begin
            frames_d = frames_q + FW'(1);
            if (frames_q == LAST_FRAME) begin
                pending_d = 1'b1;
            end
        end
    end

    // Edge-detect history and counter state.
    always_ff @(posedge clkx2in or posedge serdes_reset) begin
        if (serdes_reset) begin
            vs_q      <= 1'b0;
            frames_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            vs_q      <= vsync_i;
            frames_q  <= frames_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/dvi_link_ctrl.sv
// DVI link start-up and symbol-phase controller (clkx2in domain). Holds the
// lanes at CTRL-00 until settled and frame-aligned, then passes gearbox
// half-words through, re-aligning the slot toggle on phase slips.
module dvi_link_ctrl
    import dvi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_FRAMES   = 2
) (
    input  logic        clkx2in,
    input  logic        serdes_reset,
    input  logic        enable,
    input  logic [14:0] din,
    input  logic        din_phase,
    input  logic        vsync_in,
    output logic [4:0]  tmds_data0,
    output logic [4:0]  tmds_data1,
    output logic [4:0]  tmds_data2,
    output logic [4:0]  tmds_clk,
    output logic        link_up,
    output logic [1:0]  state,
    output logic        phase_err,
    output logic [7:0]  realign_cnt
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    link_state_e   state_q, state_d;
    logic          t_q, t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_err_q, phase_err_d;
    logic [7:0]    realign_q, realign_d;
    logic [4:0]    clk_q, clk_d;
    logic          link_up_q, link_up_d;
    logic [4:0]    lane_q [3];
    logic [4:0]    lane_d [3];
    logic          frame_pending;

    dvi_frame_sync #(
        .SYNC_FRAMES (SYNC_FRAMES)
    ) u_frame_sync (
        .clkx2in      (clkx2in),
        .serdes_reset (serdes_reset),
        .vsync_i      (vsync_in),
        .count_en_i   (state_q == ST_SYNC),
        .pending_o    (frame_pending)
    );

    // Next-state logic: start-up sequencing, slot toggle and phase tracking.
    always_comb begin
        state_d     = state_q;
        t_d         = ~t_q;
        cnt_d       = cnt_q;
        phase_err_d = phase_err_q;
        realign_d   = realign_q;
        // Only drop back on a low-half boundary so no symbol is cut in two.
        if (state_q != ST_IDLE && !enable && !t_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SYNC;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_SYNC: begin
                    if (frame_pending && !t_q && din_phase) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // din_phase should be the inverse of t; on a slip, resync t
                    // to the gearbox instead of dropping the link.
                    if (din_phase == t_q) begin
                        t_d         = ~din_phase;
                        phase_err_d = 1'b1;
                        realign_d   = sat_inc8(realign_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output slot contents; decided on state_d so the first pixel slot and
    // link_up appear on the same edge.
    always_comb begin
        clk_d     = t_q ? CLK_PAT_LO : CLK_PAT_HI;
        link_up_d = (state_d == ST_ACTIVE);
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_d[gi] = (state_d == ST_ACTIVE) ? din[gi*5 +: 5]
                              : (t_q ? CTRL_TOKEN_HI : CTRL_TOKEN_LO);
        end
    endgenerate

    // All controller state and registered outputs.
    always_ff @(posedge clkx2in or posedge serdes_reset) begin
        if (serdes_reset) begin
            state_q     <= ST_IDLE;
            t_q         <= 1'b0;
            cnt_q       <= '0;
            phase_err_q <= 1'b0;
            realign_q   <= 8'd0;
            clk_q       <= CLK_PAT_LO;
            link_up_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                lane_q[i] <= CTRL_TOKEN_LO;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            phase_err_q <= phase_err_d;
            realign_q   <= realign_d;
            clk_q       <= clk_d;
            link_up_q   <= link_up_d;
            for (int i = 0; i < 3; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign tmds_data0  = lane_q[0];
    assign tmds_data1  = lane_q[1];
    assign tmds_data2  = lane_q[2];
    assign tmds_clk    = clk_q;
    assign link_up     = link_up_q;
    assign state       = state_q;
    assign phase_err   = phase_err_q;
    assign realign_cnt = realign_q;

endmodule

// File: tb/tb_dvi_link_ctrl.sv
// Scenario bench for dvi_link_ctrl: a cycle model pushes the expected output
// word when inputs are driven; each scenario pops and compares after the edge.
module tb_dvi_link_ctrl;

    localparam int SETTLE_CYCLES = 16;
    localparam int SYNC_FRAMES   = 2;
    // {data2, data1, data0, clk, link_up, state, phase_err, realign_cnt}
    localparam logic [31:0] RST_WORD = {5'b10100, 5'b10100, 5'b10100, 5'b00000,
                                        1'b0, 2'b00, 1'b0, 8'h00};

    logic        clkx2in = 1'b0;
    logic        serdes_reset = 1'b1;
    logic        enable = 1'b0;
    logic [14:0] din = '0;
    logic        din_phase = 1'b0;
    logic        vsync_in = 1'b0;
    logic [4:0]  tmds_data0, tmds_data1, tmds_data2, tmds_clk;
    logic        link_up, phase_err;
    logic [1:0]  state;
    logic [7:0]  realign_cnt;
    logic [31:0] got;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Reference model state
    int m_state, m_cnt, m_frames, m_rcnt;
    bit m_t, m_vs, m_pend, m_err;

    always #5 clkx2in = ~clkx2in;

    dvi_link_ctrl #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SYNC_FRAMES   (SYNC_FRAMES)
    ) dut (
        .clkx2in      (clkx2in),
        .serdes_reset (serdes_reset),
        .enable       (enable),
        .din          (din),
        .din_phase    (din_phase),
        .vsync_in     (vsync_in),
        .tmds_data0   (tmds_data0),
        .tmds_data1   (tmds_data1),
        .tmds_data2   (tmds_data2),
        .tmds_clk     (tmds_clk),
        .link_up      (link_up),
        .state        (state),
        .phase_err    (phase_err),
        .realign_cnt  (realign_cnt)
    );

    assign got = {tmds_data2, tmds_data1, tmds_data0, tmds_clk, link_up, state, phase_err, realign_cnt};

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_frames = 0; m_rcnt = 0;
        m_t = 0; m_vs = 0; m_pend = 0; m_err = 0;
    endtask

    // Predict the next output word from current inputs, push it, advance one cycle.
    task automatic step();
        int ns, nc, nf, nr;
        bit nt, np, ne, rise;
        logic [4:0] d0, d1, d2, ck;
        rise = vsync_in && !m_vs;
        ns = m_state; nt = !m_t; nc = m_cnt; nf = m_frames; np = m_pend; ne = m_err; nr = m_rcnt;
        if (m_state == 2) begin
            if (rise && !m_pend) begin
                nf = m_frames + 1;
                np = (nf == SYNC_FRAMES);
            end
        end else begin
            nf = 0; np = 0;
        end
        if (m_state != 0 && !enable && !m_t) begin
            ns = 0; nc = 0;
        end else begin
            case (m_state)
                0: if (enable) begin ns = 1; nc = SETTLE_CYCLES - 1; end
                1: if (m_cnt == 0) ns = 2; else nc = m_cnt - 1;
                2: if (m_pend && !m_t && din_phase) ns = 3;
                default: if (din_phase == m_t) begin
                    nt = !din_phase; ne = 1;
                    if (nr < 255) nr = nr + 1;
                end
            endcase
        end
        if (ns == 3) {d2, d1, d0} = din;
        else begin
            d0 = m_t ? 5'b11010 : 5'b10100; d1 = d0; d2 = d0;
        end
        ck = m_t ? 5'b00000 : 5'b11111;
        exp_q.push_back({d2, d1, d0, ck, (ns == 3) ? 1'b1 : 1'b0, ns[1:0], ne, nr[7:0]});
        m_vs = vsync_in;
        @(posedge clkx2in); #1;
        m_state = ns; m_t = nt; m_cnt = nc; m_frames = nf; m_pend = np; m_err = ne; m_rcnt = nr;
    endtask

    task automatic test_reset();
        serdes_reset = 1'b1; enable = 1'b0; vsync_in = 1'b0;
        #12;
        checks++;
        if (got !== RST_WORD) begin
            errors++; $display("FAIL reset_values got=%h exp=%h", got, RST_WORD);
        end else $display("reset_values got=%h ok", got);
        @(posedge clkx2in); #1;
        serdes_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_settle();
        logic [31:0] e;
        int n_settle = 0;
        enable = 1'b1;
        for (int i = 0; i < SETTLE_CYCLES + 2; i++) begin
            din_phase = !m_t;
            // Rise lands exactly on the SETTLE->SYNC cycle; must not count.
            vsync_in = (m_state == 1 && m_cnt == 0);
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL settle_out got=%h exp=%h", got, e);
            end else $display("settle_out cyc=%0d got=%h ok", i, got);
            if (state == 2'b01) n_settle++;
        end
        checks++;
        if (n_settle !== SETTLE_CYCLES) begin
            errors++; $display("FAIL settle_len got=%0d exp=%0d", n_settle, SETTLE_CYCLES);
        end else $display("settle_len got=%0d ok", n_settle);
        checks++;
        if (state !== 2'b10) begin
            errors++; $display("FAIL settle_to_sync got=%b exp=10", state);
        end else $display("settle_to_sync ok");
    endtask

    task automatic test_sync();
        logic [31:0] e;
        bit seen = 0;
        // One further rise: with the coincident rise ignored, still short of two.
        for (int i = 0; i < 16; i++) begin
            din_phase = !m_t;
            vsync_in = (i >= 3 && i < 6);
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL sync_out got=%h exp=%h", got, e);
            end else $display("sync_out cyc=%0d got=%h ok", i, got);
        end
        checks++;
        if (state !== 2'b10) begin
            errors++; $display("FAIL sync_hold got=%b exp=10", state);
        end else $display("sync_hold ok");
        vsync_in = 1'b1;
        din = 15'h1234;
        for (int i = 0; i < 12 && !seen; i++) begin
            din_phase = !m_t;
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL sync_go got=%h exp=%h", got, e);
            end else $display("sync_go cyc=%0d got=%h ok", i, got);
            if (state === 2'b11) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL sync_timeout got=%b exp=11", state);
        end else if ({tmds_data2, tmds_data1, tmds_data0} !== 15'h1234 || link_up !== 1'b1
                     || tmds_clk !== 5'b11111) begin
            errors++;
            $display("FAIL first_active got=%h/%b/%b exp=1234/1/11111",
                     {tmds_data2, tmds_data1, tmds_data0}, link_up, tmds_clk);
        end else $display("first_active ok");
    endtask

    task automatic test_phase_slip();
        logic [31:0] e;
        for (int i = 0; i < 9; i++) begin
            din = 15'($urandom);
            din_phase = (i == 4) ? m_t : !m_t;
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL slip_out got=%h exp=%h", got, e);
            end else $display("slip_out cyc=%0d got=%h ok", i, got);
        end
        checks++;
        if (phase_err !== 1'b1 || realign_cnt !== 8'd1 || state !== 2'b11) begin
            errors++;
            $display("FAIL slip_once got=%b/%0d/%b exp=1/1/11", phase_err, realign_cnt, state);
        end else $display("slip_once ok");
    endtask

    task automatic test_saturate();
        logic [31:0] e;
        // Stuck phase slips every other cycle: 310 slips total.
        for (int i = 0; i < 620; i++) begin
            din = 15'($urandom);
            din_phase = 1'b0;
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL sat_out got=%h exp=%h", got, e);
            end else $display("sat_out cyc=%0d got=%h ok", i, got);
        end
        checks++;
        if (realign_cnt !== 8'd255 || state !== 2'b11) begin
            errors++; $display("FAIL sat_cnt got=%0d/%b exp=255/11", realign_cnt, state);
        end else $display("sat_cnt ok");
    endtask

    task automatic test_disable();
        logic [31:0] e;
        for (int i = 0; i < 3 && !m_t; i++) begin
            din_phase = !m_t; din = 15'($urandom);
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL dis_pre got=%h exp=%h", got, e);
            end else $display("dis_pre got=%h ok", got);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_phase = !m_t; din = 15'($urandom);
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL dis_out got=%h exp=%h", got, e);
            end else $display("dis_out cyc=%0d got=%h ok", i, got);
            if (i == 0) begin
                checks++;
                if (state !== 2'b11) begin
                    errors++; $display("FAIL dis_wait got=%b exp=11", state);
                end else $display("dis_wait ok");
            end
            if (i == 1) begin
                checks++;
                if (state !== 2'b00 || tmds_data0 !== 5'b10100 || link_up !== 1'b0) begin
                    errors++;
                    $display("FAIL dis_idle got=%b/%b/%b exp=00/10100/0", state, tmds_data0, link_up);
                end else $display("dis_idle ok");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int n = 0;
        enable = 1'b1;
        while (m_state != 3 && n < 120) begin
            din_phase = !m_t; din = 15'($urandom);
            vsync_in = (m_state == 2) ? ((n / 4) % 2 == 1) : 1'b0;
            step();
            n++;
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL b2b_out got=%h exp=%h", got, e);
            end else $display("b2b_out cyc=%0d got=%h ok", n, got);
        end
        checks++;
        if (state !== 2'b11) begin
            errors++; $display("FAIL b2b_timeout got=%b exp=11", state);
        end else $display("b2b_active ok");
        #3 serdes_reset = 1'b1;
        #1;
        checks++;
        if (got !== RST_WORD) begin
            errors++; $display("FAIL mid_reset got=%h exp=%h", got, RST_WORD);
        end else $display("mid_reset got=%h ok", got);
        vsync_in = 1'b0;
        @(posedge clkx2in); @(posedge clkx2in); #1;
        serdes_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            din_phase = !m_t;
            step();
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL restart_out got=%h exp=%h", got, e);
            end else $display("restart_out cyc=%0d got=%h ok", i, got);
        end
        checks++;
        if (state !== 2'b01 || phase_err !== 1'b0 || realign_cnt !== 8'd0) begin
            errors++;
            $display("FAIL restart got=%b/%b/%0d exp=01/0/0", state, phase_err, realign_cnt);
        end else $display("restart ok");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_settle();
        test_sync();
        test_phase_slip();
        test_saturate();
        test_disable();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dvi_link_ctrl.md
# dvi_link_ctrl

Link start-up and symbol-phase controller for the DVI transmitter, in the clkx2in (2× pixel) domain between the 30-to-15 gearbox and the four 5:1 output serdes. After reset or loss of BUFPLL lock it holds the link in a known idle state: clock lane running, data lanes sending the CTRL-00 token. It then waits a settle time, aligns to a frame boundary, and switches to pixel data on a symbol boundary. While active it checks gearbox half-word phase and re-aligns if it slips.

## Interface
Parameters:
- SETTLE_CYCLES, 1024: clkx2in cycles spent in SETTLE (≥2).
- SYNC_FRAMES, 2: vsync rising edges counted in SYNC before going active (≥1).

Ports:
- clkx2in  in  1  2× pixel clock; all logic on its rising edge.
- serdes_reset  in  1  asynchronous, active-high reset (reset | ~bufpll_lock).
- enable  in  1  link enable, quasi-static.
- din  in  15  gearbox half-word {ch2[4:0], ch1[4:0], ch0[4:0]}.
- din_phase  in  1  1 = din carries the low half (bits [4:0]) of each 10-bit symbol.
- vsync_in  in  1  vsync as fed to the blue encoder; rising edge = frame start.
- tmds_data0, tmds_data1, tmds_data2  out  5 each  serdes data, LSB sent first.
- tmds_clk  out  5  clock-lane pattern.
- link_up  out  1  1 while in ACTIVE.
- state  out  2  IDLE=00, SETTLE=01, SYNC=10, ACTIVE=11.
- phase_err  out  1  sticky; a phase slip was seen while ACTIVE.
- realign_cnt  out  8  saturating count of phase slips.

## Operation
- Slot toggle t: t=0 means the next output slot is a low half. t inverts every cycle, except when re-aligned.
- Idle token is CTRL-00 10'b1101010100: low half 5'b10100, high half 5'b11010.
- tmds_clk is 5'b11111 on low-half slots and 5'b00000 on high-half slots. It runs in every state.
- FSM:
  - IDLE: data lanes send the idle token. If enable=1, go to SETTLE and load the counter with SETTLE_CYCLES-1.
  - SETTLE: idle token. Decrement the counter each cycle; when it is 0, go to SYNC and clear the frame count.
  - SYNC: idle token. Count vsync rises. On the SYNC_FRAMES-th rise, set a pending flag. Go to ACTIVE on the first cycle where the pending flag is set, t=0 and din_phase=1.
  - ACTIVE: tmds_dataN ← din lane N every cycle.
- enable=0 in any non-IDLE state: go to IDLE at the next cycle with t=0, so no symbol is truncated. Counters and the pending flag clear.
- Vsync edge detection: vs_q ← vsync_in; rise = vsync_in & ~vs_q. A rise in the same cycle as the SETTLE→SYNC transition is not counted.
- Phase check (ACTIVE only): expected din_phase = ~t.
  - On mismatch: force t ← ~din_phase, set phase_err, increment realign_cnt (saturates at 255).
  - The output that cycle still carries din unchanged. State stays ACTIVE.
- phase_err and realign_cnt clear only on serdes_reset.

## Timing
- Reset values:
  - tmds_data0/1/2 = 5'b10100; tmds_clk = 5'b00000.
  - link_up=0, state=00, phase_err=0, realign_cnt=0.
  - t=0, vs_q=0, counters=0.
- All outputs are registered. din→tmds_data latency is 1 cycle. link_up rises in the same cycle as the first din-driven output.
- With enable held at 1 from reset release, SETTLE lasts exactly SETTLE_CYCLES cycles.
- ACTIVE→IDLE: the first idle low half appears in the slot where t=0.
- Reset mid-operation: all registers return to reset values immediately (async). Exit from reset is synchronous.

## Structure
- Package dvi_pkg:
  - state enum;
  - CTRL_TOKEN_LO/HI constants;
  - CLK_PAT_HI/LO constants.
- One sub-module, dvi_frame_sync: vsync edge detect plus frame counter, with pending-flag output.
- The FSM, t, and output muxing stay in dvi_link_ctrl.

## Test plan
- Reset release, enable=1, SETTLE_CYCLES=16 -> state=01 for exactly 16 cycles, then 10. Data lanes alternate 10100/11010; tmds_clk alternates 11111/00000.
- In SYNC, 2 vsync rises, din_phase aligned -> ACTIVE on the first t=0 slot after the 2nd rise. din=15'h1234 appears on the outputs 1 cycle later; link_up=1.
- In ACTIVE, invert din_phase for one cycle -> phase_err=1, realign_cnt=1, t re-aligned, no state change. 300 slips -> realign_cnt=255.
- Drop enable with t=1 pending -> state=IDLE only once t=0. The first idle output is a low half (10100).
- Assert serdes_reset while ACTIVE -> all outputs at reset values the same cycle. After release, the sequence restarts from IDLE.
- Vsync rise coincident with the SETTLE→SYNC transition -> not counted; ACTIVE requires SYNC_FRAMES further rises.
